// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver.
// Define UART_RX_BREAK_EN to add the WAIT_HIGH break state.
package uart_pkg;

  localparam int MAX_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_RX_BREAK_EN
    , S_WAIT_HIGH
`endif
  } rx_state_t;

  // Returns 1 when the parity bit disagrees with the data.
  function automatic logic parity_calc(
    input logic [MAX_BITS-1:0] d,
    input logic                pb,
    input parity_t             p
  );
    logic x;
    x = (^d) ^ pb;
    case (p)
      PAR_ODD:  return ~x;
      PAR_EVEN: return x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-word bundle with valid/ready.
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 break_det;

  modport master (
    output data, valid, frame_err,
    output parity_err, overrun, break_det,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err,
    input  parity_err, overrun, break_det,
    output ready
  );
endinterface

// File: rtl/uart_rx_filter.sv
// uart_rx_filter: 2-flop synchroniser plus hysteresis filter.
// rx only flips when the counter saturates at either end.
module uart_rx_filter #(
  parameter int FILTER_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic uart,
  output logic rx,
  output logic fall
);
  localparam logic [FILTER_W-1:0] FULL = '1;

  logic                s1, s2, rx_d;
  logic [FILTER_W-1:0] cnt, cnt_n;

  // Bring the pad signal into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= uart;
      s2 <= s1;
    end
  end

  // Saturating up/down count toward the synchronised level.
  always_comb begin
    cnt_n = cnt;
    if (s2 && cnt != FULL)
      cnt_n = cnt + 1'b1;
    else if (!s2 && cnt != '0)
      cnt_n = cnt - 1'b1;
  end

  // Counter, filtered level and its one-cycle history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= FULL;
      rx   <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      cnt  <= cnt_n;
      rx_d <= rx;
      if (cnt_n == FULL)
        rx <= 1'b1;
      else if (cnt_n == '0)
        rx <= 1'b0;
    end
  end

  assign fall = rx_d & ~rx;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, valid/ready output.
// Define UART_RX_BREAK_EN to enable break detection.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FILTER_W  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic uart,
  uart_rx_param_if.master bus
);
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int DCNT_W = $clog2(DATA_BITS + 1);
  localparam parity_t PAR = parity_t'(PARITY[1:0]);
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(CLK_DIV - 1);
  localparam logic [DCNT_W-1:0] LAST_D =
    DCNT_W'(DATA_BITS - 1);
  localparam logic LAST_S = 1'(STOP_BITS - 1);

  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_param: PARITY must be 0..2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1..2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_div
    $error("uart_rx_param: CLK_DIV out of range");
  end

  logic                  rx, fall;
  rx_state_t             state, state_n;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  sample;
  logic                  start, done;
  logic [DCNT_W-1:0]     dcnt;
  logic [DATA_BITS-1:0]  sh;
  logic                  scnt, ferr, perr;
  logic [DATA_BITS-1:0]  data_q;
  logic                  valid_q, fe_q, pe_q, ovr_q;
`ifdef UART_RX_BREAK_EN
  logic                  brk, is_brk, par_bit, brk_q;
`endif

  uart_rx_filter #(
    .FILTER_W(FILTER_W)
  ) u_filt (
    .clk (clk),
    .rst (rst),
    .uart(uart),
    .rx  (rx),
    .fall(fall)
  );

  assign sample = (state != S_IDLE) &&
                  (bit_cnt == '0);

`ifdef UART_RX_BREAK_EN
  assign is_brk = (scnt == 1'b0) && (sh == '0) &&
                  (PAR == PAR_NONE || !par_bit) &&
                  !rx;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  // Next state and per-cycle strobes.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    done    = 1'b0;
`ifdef UART_RX_BREAK_EN
    brk     = 1'b0;
`endif
    unique case (state)
      S_IDLE:
        if (fall) begin
          state_n = S_START;
          start   = 1'b1;
        end
      S_START:
        if (sample)
          state_n = rx ? S_IDLE : S_DATA;
      S_DATA:
        if (sample && dcnt == LAST_D)
          state_n = (PAR == PAR_NONE) ?
                    S_STOP : S_PARITY;
      S_PARITY:
        if (sample)
          state_n = S_STOP;
      S_STOP:
        if (sample) begin
`ifdef UART_RX_BREAK_EN
          if (is_brk) begin
            brk     = 1'b1;
            state_n = S_WAIT_HIGH;
          end else
`endif
          if (scnt == LAST_S) begin
            done    = 1'b1;
            state_n = S_IDLE;
          end
        end
`ifdef UART_RX_BREAK_EN
      S_WAIT_HIGH:
        if (rx)
          state_n = S_IDLE;
`endif
      default:
        state_n = S_IDLE;
    endcase
  end

  // Bit timer: half period to mid start bit, then full.
  always_ff @(posedge clk) begin
    if (rst)
      bit_cnt <= '0;
    else if (start)
      bit_cnt <= HALF;
    else if (state != S_IDLE)
      bit_cnt <= (bit_cnt == '0) ?
                 FULL : bit_cnt - 1'b1;
  end

  // Character datapath: shift, parity and stop capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      sh   <= '0;
      scnt <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
`ifdef UART_RX_BREAK_EN
      par_bit <= 1'b0;
`endif
    end else begin
      if (start) begin
        dcnt <= '0;
        scnt <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == S_DATA && sample) begin
        sh   <= {rx, sh[DATA_BITS-1:1]};
        dcnt <= dcnt + 1'b1;
      end
      if (state == S_PARITY && sample) begin
        perr <= parity_calc(MAX_BITS'(sh), rx, PAR);
`ifdef UART_RX_BREAK_EN
        par_bit <= rx;
`endif
      end
      if (state == S_STOP && sample) begin
        ferr <= ferr | ~rx;
        if (scnt != LAST_S)
          scnt <= scnt + 1'b1;
      end
    end
  end

  // Single-entry output register with overrun drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!valid_q || bus.ready) begin
          data_q  <= sh;
          fe_q    <= ferr | ~rx;
          pe_q    <= perr;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_EN
  // One-cycle break pulse.
  always_ff @(posedge clk) begin
    if (rst)
      brk_q <= 1'b0;
    else
      brk_q <= brk;
  end
  assign bus.break_det = brk_q;
`else
  assign bus.break_det = 1'b0;
`endif

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = fe_q;
  assign bus.parity_err = pe_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench with a frame-level model.
// Covers 8N1 and 7E2 receivers; honours UART_RX_BREAK_EN.
module tb_uart_rx_param;

  localparam int CD = 16;
  // filter (2 + 3) + start detect (1) + half bit
  localparam int LAT0 = 2 + 3 + 1 + CD / 2;
`ifdef UART_RX_BREAK_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [8:0] d;
    bit         fe;
    bit         pe;
    bit         pb;
    bit         brk;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ln8 = 1'b1;
  logic ln7 = 1'b1;

  uart_rx_param_if #(.DATA_BITS(8)) b8 ();
  uart_rx_param_if #(.DATA_BITS(7)) b7 ();

  uart_rx_param #(
    .CLK_DIV(CD)
  ) u8 (
    .clk (clk),
    .rst (rst),
    .uart(ln8),
    .bus (b8)
  );

  uart_rx_param #(
    .CLK_DIV  (CD),
    .DATA_BITS(7),
    .PARITY   (2),
    .STOP_BITS(2)
  ) u7 (
    .clk (clk),
    .rst (rst),
    .uart(ln7),
    .bus (b7)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ev_t        q0[$];
  ev_t        q1[$];
  bit         m_valid[2];
  logic [8:0] m_data[2];
  bit         m_fe[2];
  bit         m_pe[2];
  bit         m_ovr[2];
  bit         m_brk[2];
  bit         pv[2];
  int         n_vr[2];
  int         n_ov[2];
  int         n_bk[2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Output register rule applied to scheduled completions.
  task automatic mstep(input int i);
    ev_t  e;
    bit   due;
    logic rdy;
    rdy = (i == 0) ? b8.ready : b7.ready;
    m_ovr[i] = 1'b0;
    m_brk[i] = 1'b0;
    due = 1'b0;
    if (rst) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_fe[i]    = 1'b0;
      m_pe[i]    = 1'b0;
      if (i == 0) q0.delete();
      else q1.delete();
    end else begin
      if (i == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
        e = q0.pop_front();
        due = 1'b1;
      end
      if (i == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        due = 1'b1;
      end
      if (due && e.brk) m_brk[i] = 1'b1;
      if (due && !e.brk) begin
        if (!m_valid[i] || rdy) begin
          m_valid[i] = 1'b1;
          m_data[i]  = e.d;
          m_fe[i]    = e.fe;
          m_pe[i]    = e.pe;
        end else begin
          m_ovr[i] = 1'b1;
        end
      end else if (m_valid[i] && rdy) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic cmp(input int i);
    logic [8:0] ad;
    logic av, afe, ape, aov, abk;
    if (i == 0) begin
      ad  = {1'b0, b8.data};
      av  = b8.valid;
      afe = b8.frame_err;
      ape = b8.parity_err;
      aov = b8.overrun;
      abk = b8.break_det;
    end else begin
      ad  = {2'b0, b7.data};
      av  = b7.valid;
      afe = b7.frame_err;
      ape = b7.parity_err;
      aov = b7.overrun;
      abk = b7.break_det;
    end
    chk($sformatf("valid%0d", i), 32'(av), 32'(m_valid[i]));
    chk($sformatf("ovr%0d", i), 32'(aov), 32'(m_ovr[i]));
    chk($sformatf("brk%0d", i), 32'(abk), 32'(m_brk[i]));
    if (m_valid[i]) begin
      chk($sformatf("data%0d", i), 32'(ad), 32'(m_data[i]));
      chk($sformatf("fe%0d", i), 32'(afe), 32'(m_fe[i]));
      chk($sformatf("pe%0d", i), 32'(ape), 32'(m_pe[i]));
    end
    if (av && !pv[i]) n_vr[i]++;
    pv[i] = av;
    if (aov) n_ov[i]++;
    if (abk) n_bk[i]++;
  endtask

  // One clock: model after the edge, compare at negedge.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    mstep(0);
    mstep(1);
    @(negedge clk);
    cmp(0);
    cmp(1);
  endtask

  task automatic line(input int i, input logic v);
    if (i == 0) ln8 = v;
    else ln7 = v;
  endtask

  // Drive one character and schedule its model outcome.
  task automatic send(input int i, input logic [8:0] d,
                      input bit pflip, input bit st0,
                      input bit st1, output ev_t e);
    int         db, sb, np, nb;
    logic [8:0] dm;
    logic       fr [12];
    db = (i == 0) ? 8 : 7;
    sb = (i == 0) ? 1 : 2;
    np = (i == 0) ? 0 : 1;
    dm = d & ((9'h1 << db) - 9'h1);
    e.pb = (^dm) ^ pflip;
    nb = 0;
    fr[nb] = 1'b0;
    nb++;
    for (int k = 0; k < db; k++) begin
      fr[nb] = dm[k];
      nb++;
    end
    if (np == 1) begin
      fr[nb] = e.pb;
      nb++;
    end
    fr[nb] = st0;
    nb++;
    if (sb == 2) begin
      fr[nb] = st1;
      nb++;
    end
    e.d   = dm;
    e.fe  = !st0 || (sb == 2 && !st1);
    e.pe  = (np == 1) && (((^dm) ^ e.pb) != 1'b0);
    e.brk = BRK && (dm == '0) &&
            (np == 0 || !e.pb) && !st0;
    e.cyc = e.brk ? cyc + LAT0 + CD * (db + np + 1)
                  : cyc + LAT0 + CD * (db + np + sb);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
    for (int k = 0; k < nb; k++) begin
      line(i, fr[k]);
      repeat (CD) cycle();
    end
  endtask

  initial begin
    ev_t e;
    int  k0, s_vr, s_ov, s_bk;
    b8.ready = 1'b1;
    b7.ready = 1'b1;
    repeat (3) cycle();
    chk("rst_valid", 32'(b8.valid), 0);
    chk("rst_data", 32'(b8.data), 0);
    rst = 1'b0;
    repeat (10) cycle();

    // 8N1 0xA5 with ready high
    s_vr = n_vr[0];
    k0 = cyc;
    send(0, 9'h0A5, 1'b0, 1'b1, 1'b1, e);
    chk("sched_a5", e.cyc - k0, 158);
    repeat (20) cycle();
    chk("a5_words", n_vr[0] - s_vr, 1);
    chk("a5_data", 32'(b8.data), 32'h0A5);

    // 7E2 0x41: good parity, then flipped
    s_vr = n_vr[1];
    send(1, 9'h041, 1'b0, 1'b1, 1'b1, e);
    chk("pb_41", 32'(e.pb), 0);
    chk("pe_41", 32'(e.pe), 0);
    send(1, 9'h041, 1'b1, 1'b1, 1'b1, e);
    chk("pe_41f", 32'(e.pe), 1);
    repeat (20) cycle();
    chk("e2_words", n_vr[1] - s_vr, 2);
    chk("e2_data", 32'(b7.data), 32'h41);

    // overrun: ready low, two characters back to back
    b8.ready = 1'b0;
    s_ov = n_ov[0];
    send(0, 9'h011, 1'b0, 1'b1, 1'b1, e);
    send(0, 9'h022, 1'b0, 1'b1, 1'b1, e);
    repeat (10) cycle();
    chk("ovr_valid", 32'(b8.valid), 1);
    chk("ovr_data", 32'(b8.data), 32'h11);
    chk("ovr_pulses", n_ov[0] - s_ov, 1);
    b8.ready = 1'b1;
    repeat (2) cycle();
    chk("ovr_clear", 32'(b8.valid), 0);

    // glitch and short pulse on idle line
    s_vr = n_vr[0];
    line(0, 1'b0);
    repeat (3) cycle();
    line(0, 1'b1);
    repeat (40) cycle();
    line(0, 1'b0);
    repeat (6) cycle();
    line(0, 1'b1);
    repeat (60) cycle();
    chk("glitch_words", n_vr[0] - s_vr, 0);
    send(0, 9'h05A, 1'b0, 1'b1, 1'b1, e);
    repeat (20) cycle();
    chk("glitch_recov", 32'(b8.data), 32'h5A);

    // stop bit forced low
    s_vr = n_vr[0];
    send(0, 9'h03C, 1'b0, 1'b0, 1'b1, e);
    chk("fe_model", 32'(e.fe), 1);
    line(0, 1'b1);
    repeat (40) cycle();
    chk("fe_words", n_vr[0] - s_vr, 1);
    chk("fe_data", 32'(b8.data), 32'h3C);

    // line low for 20 bit times
    s_vr = n_vr[0];
    s_bk = n_bk[0];
    send(0, 9'h000, 1'b0, 1'b0, 1'b1, e);
    repeat (10 * CD) cycle();
    line(0, 1'b1);
    repeat (60) cycle();
    chk("brk_words", n_vr[0] - s_vr, BRK ? 0 : 1);
    chk("brk_pulses", n_bk[0] - s_bk, BRK ? 1 : 0);
    send(0, 9'h096, 1'b0, 1'b1, 1'b1, e);
    repeat (20) cycle();
    chk("brk_recov", 32'(b8.data), 32'h96);

    // reset in the middle of the data bits
    s_vr = n_vr[0];
    line(0, 1'b0);
    repeat (CD) cycle();
    line(0, 1'b1);
    repeat (2 * CD) cycle();
    line(0, 1'b0);
    repeat (CD / 2) cycle();
    rst = 1'b1;
    line(0, 1'b1);
    repeat (2) cycle();
    rst = 1'b0;
    chk("mid_valid", 32'(b8.valid), 0);
    chk("mid_data", 32'(b8.data), 0);
    repeat (200) cycle();
    chk("mid_words", n_vr[0] - s_vr, 0);
    send(0, 9'h0C3, 1'b0, 1'b1, 1'b1, e);
    repeat (20) cycle();
    chk("mid_recov", 32'(b8.data), 32'hC3);
    chk("mid_recov_n", n_vr[0] - s_vr, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
